// File: rtl/imem_loader_pkg.sv
// Shared definitions for the boot-time instruction memory loader: FSM encoding,
// word geometry and the image capacity rule.
package imem_loader_pkg;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned WORD_WIDTH     = 8 * BYTES_PER_WORD;
    localparam int unsigned BYTE_CNT_WIDTH = $clog2(BYTES_PER_WORD);

    typedef enum logic [2:0] {
        StHdr0  = 3'd0,
        StHdr1  = 3'd1,
        StData  = 3'd2,
        StCsum  = 3'd3,
        StDone  = 3'd4,
        StError = 3'd5
    } loader_state_e;

    // Words that fit between the base address and the top of the byte-addressed memory.
    function automatic logic [31:0] capacity_words(input int unsigned addr_w,
                                                   input logic [31:0] base_addr);
        return (32'd1 << (addr_w - 2)) - (base_addr >> 2);
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader, bundled as one
// interface; the loader takes the slave view, the environment the master view.
interface imem_loader_if #(
    parameter int unsigned AddrWidth = 16,
    parameter int unsigned DataWidth = 32
);

    logic [7:0]           in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic                 imem_we;
    logic [AddrWidth-1:0] imem_addr;
    logic [DataWidth-1:0] imem_wdata;

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output imem_we,
        output imem_addr,
        output imem_wdata
    );

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata
    );

endinterface

// File: rtl/imem_word_packer.sv
// Assembles accepted payload bytes into little-endian words and pulses word_valid_o
// for one cycle after the last byte of each word.
module imem_word_packer
    import imem_loader_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            byte_i,
    input  logic                  byte_en_i,
    output logic                  cnt_full_o,
    output logic [WORD_WIDTH-1:0] word_o,
    output logic                  word_valid_o
);

    logic [BYTE_CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [WORD_WIDTH-1:0]     word_q, word_d;
    logic                      valid_q, valid_d;

    // Next accepted byte completes the word; no dependency on byte_en_i.
    assign cnt_full_o = (cnt_q == BYTE_CNT_WIDTH'(BYTES_PER_WORD - 1));

    always_comb begin
        cnt_d   = cnt_q;
        word_d  = word_q;
        valid_d = 1'b0;
        if (byte_en_i) begin
            cnt_d                        = cnt_q + BYTE_CNT_WIDTH'(1);
            word_d[{cnt_q, 3'b000} +: 8] = byte_i;
            valid_d                      = cnt_full_o;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            valid_q <= valid_d;
        end
    end

    assign word_o       = word_q;
    assign word_valid_o = valid_q;

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses a counted, XOR-checksummed byte stream into instruction memory
// and releases the core from reset only after a verified image.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned INST_MEMORY_ADDR_BUS_WIDTH = 16,
    parameter int unsigned INST_MEMORY_DATA_BUS_WIDTH = 32,
    parameter logic [INST_MEMORY_ADDR_BUS_WIDTH-1:0] BASE_ADDR = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          restart,
    imem_loader_if.slave  bus,
    output logic          cpu_rst_n,
    output logic          done,
    output logic          error,
    output logic [15:0]   words_loaded
);

    localparam int unsigned AW       = INST_MEMORY_ADDR_BUS_WIDTH;
    localparam logic [31:0] CapWords = capacity_words(AW, 32'(BASE_ADDR));

    loader_state_e state_q, state_d;
    logic [15:0]   count_q, count_d;
    logic [15:0]   words_rx_q, words_rx_d;
    logic [15:0]   words_loaded_q, words_loaded_d;
    logic [7:0]    csum_q, csum_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          in_ready_q, in_ready_d;
    logic          done_q, done_d;
    logic          error_q, error_d;
    logic          cpu_rst_n_q, cpu_rst_n_d;

    logic                  hs;
    logic                  byte_en;
    logic                  cnt_full;
    logic                  word_valid;
    logic [WORD_WIDTH-1:0] word;
    logic [15:0]           n_hdr;

    assign hs    = bus.in_valid && in_ready_q;
    assign n_hdr = {bus.in_data, count_q[7:0]};

    imem_word_packer u_packer (
        .clk          (clk),
        .rst_n        (rst_n),
        .byte_i       (bus.in_data),
        .byte_en_i    (byte_en),
        .cnt_full_o   (cnt_full),
        .word_o       (word),
        .word_valid_o (word_valid)
    );

    always_comb begin
        state_d        = state_q;
        count_d        = count_q;
        words_rx_d     = words_rx_q;
        words_loaded_d = words_loaded_q;
        csum_d         = csum_q;
        addr_d         = addr_q;
        byte_en        = 1'b0;

        if (word_valid) begin
            words_loaded_d = words_loaded_q + 16'd1;
        end

        unique case (state_q)
            StHdr0: begin
                if (hs) begin
                    count_d[7:0] = bus.in_data;
                    state_d      = StHdr1;
                end
            end
            StHdr1: begin
                if (hs) begin
                    count_d[15:8] = bus.in_data;
                    if ({16'd0, n_hdr} > CapWords) begin
                        state_d = StError;
                    end else if (n_hdr == 16'd0) begin
                        state_d = StCsum;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (hs) begin
                    byte_en = 1'b1;
                    csum_d  = csum_q ^ bus.in_data;
                    // Address is latched with the word so the write lands one cycle later.
                    if (cnt_full) begin
                        addr_d     = BASE_ADDR + AW'({words_rx_q, 2'b00});
                        words_rx_d = words_rx_q + 16'd1;
                        if (words_rx_q + 16'd1 == count_q) begin
                            state_d = StCsum;
                        end
                    end
                end
            end
            StCsum: begin
                if (hs) begin
                    state_d = (bus.in_data == csum_q) ? StDone : StError;
                end
            end
            StDone, StError: begin
                if (restart) begin
                    state_d        = StHdr0;
                    words_loaded_d = 16'd0;
                    words_rx_d     = 16'd0;
                    csum_d         = 8'd0;
                end
            end
            default: state_d = StHdr0;
        endcase

        in_ready_d  = state_d inside {StHdr0, StHdr1, StData, StCsum};
        done_d      = (state_d == StDone);
        error_d     = (state_d == StError);
        // Core leaves reset one cycle after DONE is entered and drops with restart.
        cpu_rst_n_d = (state_q == StDone) && (state_d == StDone);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StHdr0;
            count_q        <= 16'd0;
            words_rx_q     <= 16'd0;
            words_loaded_q <= 16'd0;
            csum_q         <= 8'd0;
            addr_q         <= '0;
            in_ready_q     <= 1'b0;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
            cpu_rst_n_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            words_rx_q     <= words_rx_d;
            words_loaded_q <= words_loaded_d;
            csum_q         <= csum_d;
            addr_q         <= addr_d;
            in_ready_q     <= in_ready_d;
            done_q         <= done_d;
            error_q        <= error_d;
            cpu_rst_n_q    <= cpu_rst_n_d;
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.imem_we    = word_valid;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = INST_MEMORY_DATA_BUS_WIDTH'(word);
    assign words_loaded   = words_loaded_q;
    assign done           = done_q;
    assign error          = error_q;
    assign cpu_rst_n      = cpu_rst_n_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: images are built and judged by a reference model
// that works from the stream format (header count, payload XOR, word layout).
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        restart;
    logic        cpu_rst_n;
    logic        done;
    logic        error;
    logic [15:0] words_loaded;

    imem_loader_if #(.AddrWidth(16), .DataWidth(32)) bus ();

    imem_loader #(
        .INST_MEMORY_ADDR_BUS_WIDTH (16),
        .INST_MEMORY_DATA_BUS_WIDTH (32),
        .BASE_ADDR                  (16'h0000)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .restart      (restart),
        .bus          (bus.slave),
        .cpu_rst_n    (cpu_rst_n),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [7:0]  pay_q[$];
    logic [7:0]  stream_q[$];
    logic [15:0] got_addr[$];
    logic [31:0] got_data[$];

    // One entry per cycle of imem_we; a stretched pulse shows up as an extra write.
    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            got_addr.push_back(bus.imem_addr);
            got_data.push_back(bus.imem_wdata);
        end
    end

    task automatic apply_reset();
        rst_n        = 1'b0;
        restart      = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        got_addr.delete();
        got_data.delete();
    endtask

    task automatic send_stream(input int gap_pct);
        int t;
        foreach (stream_q[i]) begin
            while ($urandom_range(99) < gap_pct) begin
                bus.in_valid = 1'b0;
                bus.in_data  = 8'($urandom);
                @(posedge clk);
                #1;
            end
            bus.in_valid = 1'b1;
            bus.in_data  = stream_q[i];
            t = 0;
            while (bus.in_ready !== 1'b1 && t < 100) begin
                @(posedge clk);
                #1;
                t++;
            end
            if (t >= 100) begin
                n_cmp++;
                n_bad++;
                $display("FAIL handshake_timeout byte %0d: in_ready=%b, required 1", i,
                         bus.in_ready);
                bus.in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
    endtask

    // Reference model: capacity 2^(16-2) words at base 0, checksum = XOR of payload.
    task automatic run_image(input string name, input logic [15:0] n, input logic [7:0] csum,
                             input int gap_pct);
        logic [7:0]  x;
        logic        cap_err;
        logic        exp_done;
        int          exp_words;
        logic [31:0] exp_word;
        x = 8'h00;
        foreach (pay_q[i]) x ^= pay_q[i];
        cap_err   = (n > 16'd16384);
        exp_done  = !cap_err && (csum == x);
        exp_words = cap_err ? 0 : int'(n);
        stream_q.delete();
        stream_q.push_back(n[7:0]);
        stream_q.push_back(n[15:8]);
        if (!cap_err) begin
            foreach (pay_q[i]) stream_q.push_back(pay_q[i]);
            stream_q.push_back(csum);
        end
        got_addr.delete();
        got_data.delete();
        send_stream(gap_pct);

        n_cmp++;
        if (done !== exp_done || error !== !exp_done || cpu_rst_n !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_immediate: done=%b error=%b cpu_rst_n=%b, required %b %b 0",
                     name, done, error, cpu_rst_n, exp_done, !exp_done);
        end
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (done !== exp_done || error !== !exp_done || cpu_rst_n !== exp_done) begin
            n_bad++;
            $display("FAIL %s_final: done=%b error=%b cpu_rst_n=%b, required %b %b %b",
                     name, done, error, cpu_rst_n, exp_done, !exp_done, exp_done);
        end
        n_cmp++;
        if (bus.in_ready !== 1'b0 || words_loaded !== 16'(exp_words)) begin
            n_bad++;
            $display("FAIL %s_status: in_ready=%b words_loaded=%0d, required 0 %0d",
                     name, bus.in_ready, words_loaded, exp_words);
        end
        n_cmp++;
        if (got_addr.size() != exp_words) begin
            n_bad++;
            $display("FAIL %s_write_count: got %0d writes, required %0d", name,
                     got_addr.size(), exp_words);
        end
        for (int i = 0; i < exp_words && i < got_addr.size(); i++) begin
            exp_word = {pay_q[4*i+3], pay_q[4*i+2], pay_q[4*i+1], pay_q[4*i]};
            n_cmp++;
            if (got_addr[i] !== 16'(4 * i) || got_data[i] !== exp_word) begin
                n_bad++;
                $display("FAIL %s_write%0d: got %h @%h, required %h @%h", name, i,
                         got_data[i], got_addr[i], exp_word, 16'(4 * i));
            end
        end
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        restart      = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({bus.in_ready, bus.imem_we, cpu_rst_n, done, error} !== 5'b0 ||
            bus.imem_addr !== 16'h0 || bus.imem_wdata !== 32'h0 || words_loaded !== 16'h0) begin
            n_bad++;
            $display("FAIL reset_outputs: rdy=%b we=%b cpu=%b done=%b err=%b a=%h d=%h wl=%0d, required all 0",
                     bus.in_ready, bus.imem_we, cpu_rst_n, done, error, bus.imem_addr,
                     bus.imem_wdata, words_loaded);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (bus.in_ready !== 1'b1 || done !== 1'b0 || error !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_release: in_ready=%b done=%b error=%b, required 1 0 0",
                     bus.in_ready, done, error);
        end
    endtask

    task automatic load_known_payload();
        pay_q = '{8'h13, 8'h05, 8'h00, 8'h00, 8'hB3, 8'h00, 8'h10, 8'h00};
    endtask

    task automatic test_known_image();
        apply_reset();
        load_known_payload();
        // XOR of these eight payload bytes is 0xB5.
        run_image("known_good", 16'd2, 8'hB5, 0);
    endtask

    task automatic test_bad_checksum();
        apply_reset();
        load_known_payload();
        run_image("csum_zero", 16'd2, 8'h00, 0);
    endtask

    task automatic test_empty_image();
        pay_q.delete();
        apply_reset();
        run_image("empty_good", 16'd0, 8'h00, 0);
        apply_reset();
        run_image("empty_bad", 16'd0, 8'h01, 0);
    endtask

    task automatic test_capacity();
        pay_q.delete();
        apply_reset();
        run_image("oversize", 16'h4001, 8'h00, 0);
        // Exactly at capacity the header is accepted and the loader waits for payload.
        apply_reset();
        stream_q = '{8'h00, 8'h40};
        send_stream(0);
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (error !== 1'b0 || bus.in_ready !== 1'b1 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL capacity_edge: error=%b in_ready=%b done=%b, required 0 1 0",
                     error, bus.in_ready, done);
        end
    endtask

    task automatic test_gaps();
        apply_reset();
        load_known_payload();
        run_image("gappy", 16'd2, 8'hB5, 50);
    endtask

    task automatic test_reset_midload();
        apply_reset();
        load_known_payload();
        stream_q = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h00, 8'h00, 8'hB3};
        send_stream(0);
        n_cmp++;
        if (words_loaded !== 16'd1) begin
            n_bad++;
            $display("FAIL midload_progress: words_loaded=%0d, required 1", words_loaded);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.in_ready, bus.imem_we, cpu_rst_n, done, error} !== 5'b0 ||
            bus.imem_addr !== 16'h0 || bus.imem_wdata !== 32'h0 || words_loaded !== 16'h0) begin
            n_bad++;
            $display("FAIL midload_async_clear: rdy=%b we=%b cpu=%b a=%h d=%h wl=%0d, required all 0",
                     bus.in_ready, bus.imem_we, cpu_rst_n, bus.imem_addr, bus.imem_wdata,
                     words_loaded);
        end
        apply_reset();
        run_image("reload", 16'd2, 8'hB5, 0);
    endtask

    task automatic test_restart();
        apply_reset();
        load_known_payload();
        run_image("pre_restart", 16'd2, 8'hB5, 0);
        restart = 1'b1;
        @(posedge clk);
        #1 restart = 1'b0;
        n_cmp++;
        if (cpu_rst_n !== 1'b0 || done !== 1'b0 || error !== 1'b0 || words_loaded !== 16'd0 ||
            bus.in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL restart_done: cpu=%b done=%b err=%b wl=%0d rdy=%b, required 0 0 0 0 1",
                     cpu_rst_n, done, error, words_loaded, bus.in_ready);
        end
        // A second image after restart must start again at address 0 with a clean checksum.
        run_image("after_restart", 16'd2, 8'hB5, 0);
    endtask

    task automatic test_random();
        logic [15:0] n;
        logic [7:0]  x;
        logic [7:0]  csum;
        for (int it = 0; it < 8; it++) begin
            apply_reset();
            n = 16'($urandom_range(1, 6));
            pay_q.delete();
            x = 8'h00;
            for (int b = 0; b < 4 * int'(n); b++) begin
                pay_q.push_back(8'($urandom));
                x ^= pay_q[b];
            end
            csum = ($urandom_range(2) == 0) ? (x ^ 8'($urandom_range(1, 255))) : x;
            run_image($sformatf("random%0d", it), n, csum, $urandom_range(60));
        end
    endtask

    initial begin
        test_reset();
        test_known_image();
        test_bad_checksum();
        test_empty_image();
        test_capacity();
        test_gaps();
        test_reset_midload();
        test_restart();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at time limit, required completion");
        $fatal(1);
    end

endmodule
